// File: rtl/bus.sv
// Single-cycle interconnect: instruction fetch and store buffer masters to the TCM and CLINT slaves.
// Request strobes and offsets are combinational; acks and read-data selection are registered one cycle.
module bus #(
   parameter int ADDR_WIDTH        = 32,
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int FETCH_WIDTH       = 4,
   parameter int REG_DATA_WIDTH    = 32,
   parameter int BUS_DATA_WIDTH    = INSTRUCTION_WIDTH * FETCH_WIDTH,
   parameter int SIZE_WIDTH        = 2,
   parameter logic [ADDR_WIDTH-1:0] TCM_ADDR   = 32'h8000_0000,
   parameter logic [ADDR_WIDTH-1:0] TCM_SIZE   = 32'h0001_0000,
   parameter logic [ADDR_WIDTH-1:0] CLINT_ADDR = 32'h2000_0000,
   parameter logic [ADDR_WIDTH-1:0] CLINT_SIZE = 32'h0001_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_WIDTH-1:0]     fetch_bus_addr,
   input  logic                      fetch_bus_read_req,
   output logic [BUS_DATA_WIDTH-1:0] bus_fetch_data,
   output logic                      bus_fetch_read_ack,
   input  logic [ADDR_WIDTH-1:0]     stbuf_bus_read_addr,
   input  logic [ADDR_WIDTH-1:0]     stbuf_bus_write_addr,
   input  logic [SIZE_WIDTH-1:0]     stbuf_bus_read_size,
   input  logic [SIZE_WIDTH-1:0]     stbuf_bus_write_size,
   input  logic [REG_DATA_WIDTH-1:0] stbuf_bus_data,
   input  logic                      stbuf_bus_read_req,
   input  logic                      stbuf_bus_write_req,
   output logic [REG_DATA_WIDTH-1:0] bus_stbuf_data,
   output logic                      bus_stbuf_read_ack,
   output logic                      bus_stbuf_write_ack,
   output logic [ADDR_WIDTH-1:0]     bus_tcm_fetch_addr,
   output logic                      bus_tcm_fetch_rd,
   input  logic [BUS_DATA_WIDTH-1:0] tcm_bus_fetch_data,
   output logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_read_addr,
   output logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_write_addr,
   output logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_read_size,
   output logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_write_size,
   output logic [REG_DATA_WIDTH-1:0] bus_tcm_stbuf_data,
   output logic                      bus_tcm_stbuf_rd,
   output logic                      bus_tcm_stbuf_wr,
   input  logic [BUS_DATA_WIDTH-1:0] tcm_bus_stbuf_data,
   output logic [ADDR_WIDTH-1:0]     bus_clint_read_addr,
   output logic [ADDR_WIDTH-1:0]     bus_clint_write_addr,
   output logic [SIZE_WIDTH-1:0]     bus_clint_read_size,
   output logic [SIZE_WIDTH-1:0]     bus_clint_write_size,
   output logic [REG_DATA_WIDTH-1:0] bus_clint_data,
   output logic                      bus_clint_rd,
   output logic                      bus_clint_wr,
   input  logic [BUS_DATA_WIDTH-1:0] clint_bus_data
);

   // One extra bit keeps a window that ends at the top of the address space from wrapping.
   function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [ADDR_WIDTH-1:0] base,
                                      input logic [ADDR_WIDTH-1:0] size);
      logic [ADDR_WIDTH:0] top;
      top = {1'b0, base} + {1'b0, size};
      return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < top);
   endfunction

   logic fetch_hit_tcm;
   logic rd_hit_tcm;
   logic rd_hit_clint;
   logic wr_hit_tcm;
   logic wr_hit_clint;

   logic fetch_vld_p1;
   logic rd_vld_p1;
   logic wr_vld_p1;
   logic fetch_sel_tcm_p1;
   logic rd_sel_tcm_p1;
   logic rd_sel_clint_p1;

   assign fetch_hit_tcm = in_window(fetch_bus_addr, TCM_ADDR, TCM_SIZE);
   assign rd_hit_tcm    = in_window(stbuf_bus_read_addr, TCM_ADDR, TCM_SIZE);
   assign rd_hit_clint  = in_window(stbuf_bus_read_addr, CLINT_ADDR, CLINT_SIZE);
   assign wr_hit_tcm    = in_window(stbuf_bus_write_addr, TCM_ADDR, TCM_SIZE);
   assign wr_hit_clint  = in_window(stbuf_bus_write_addr, CLINT_ADDR, CLINT_SIZE);

   // Stage p0: request side, offsets always driven, strobes gated by decode
   assign bus_tcm_fetch_addr       = fetch_bus_addr - TCM_ADDR;
   assign bus_tcm_fetch_rd         = fetch_bus_read_req & fetch_hit_tcm;

   assign bus_tcm_stbuf_read_addr  = stbuf_bus_read_addr - TCM_ADDR;
   assign bus_tcm_stbuf_write_addr = stbuf_bus_write_addr - TCM_ADDR;
   assign bus_tcm_stbuf_read_size  = stbuf_bus_read_size;
   assign bus_tcm_stbuf_write_size = stbuf_bus_write_size;
   assign bus_tcm_stbuf_data       = stbuf_bus_data;
   assign bus_tcm_stbuf_rd         = stbuf_bus_read_req & rd_hit_tcm;
   assign bus_tcm_stbuf_wr         = stbuf_bus_write_req & wr_hit_tcm;

   assign bus_clint_read_addr      = stbuf_bus_read_addr - CLINT_ADDR;
   assign bus_clint_write_addr     = stbuf_bus_write_addr - CLINT_ADDR;
   assign bus_clint_read_size      = stbuf_bus_read_size;
   assign bus_clint_write_size     = stbuf_bus_write_size;
   assign bus_clint_data           = stbuf_bus_data;
   assign bus_clint_rd             = stbuf_bus_read_req & rd_hit_clint;
   assign bus_clint_wr             = stbuf_bus_write_req & wr_hit_clint;

   // Stage p1: acks and read-path selectors, captured only for an actual request
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_vld_p1     <= 1'b0;
         rd_vld_p1        <= 1'b0;
         wr_vld_p1        <= 1'b0;
         fetch_sel_tcm_p1 <= 1'b0;
         rd_sel_tcm_p1    <= 1'b0;
         rd_sel_clint_p1  <= 1'b0;
      end else begin
         fetch_vld_p1     <= fetch_bus_read_req;
         rd_vld_p1        <= stbuf_bus_read_req;
         wr_vld_p1        <= stbuf_bus_write_req;
         fetch_sel_tcm_p1 <= fetch_bus_read_req & fetch_hit_tcm;
         rd_sel_tcm_p1    <= stbuf_bus_read_req & rd_hit_tcm;
         rd_sel_clint_p1  <= stbuf_bus_read_req & rd_hit_clint;
      end
   end

   assign bus_fetch_read_ack  = fetch_vld_p1;
   assign bus_stbuf_read_ack  = rd_vld_p1;
   assign bus_stbuf_write_ack = wr_vld_p1;

   assign bus_fetch_data = fetch_sel_tcm_p1 ? tcm_bus_fetch_data : '0;

   always_comb begin
      bus_stbuf_data = '0;
      if (rd_sel_tcm_p1)
         bus_stbuf_data = tcm_bus_stbuf_data[REG_DATA_WIDTH-1:0];
      else if (rd_sel_clint_p1)
         bus_stbuf_data = clint_bus_data[REG_DATA_WIDTH-1:0];
   end

   // Slaves return LSB-aligned load data; the upper lanes are never consumed.
   logic unused_hi;
   assign unused_hi = ^{tcm_bus_stbuf_data[BUS_DATA_WIDTH-1:REG_DATA_WIDTH],
                        clint_bus_data[BUS_DATA_WIDTH-1:REG_DATA_WIDTH]};

endmodule

// File: tb/tb_bus.sv
// Bench for bus: directed steps followed by randomized traffic, checked against an address-window model.
module tb_bus;
   localparam logic [31:0] TCM_A   = 32'h8000_0000;
   localparam logic [31:0] TCM_S   = 32'h0001_0000;
   localparam logic [31:0] CLINT_A = 32'h2000_0000;
   localparam logic [31:0] CLINT_S = 32'h0001_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [31:0]  fetch_bus_addr;
   logic         fetch_bus_read_req;
   logic [127:0] bus_fetch_data;
   logic         bus_fetch_read_ack;
   logic [31:0]  stbuf_bus_read_addr, stbuf_bus_write_addr;
   logic [1:0]   stbuf_bus_read_size, stbuf_bus_write_size;
   logic [31:0]  stbuf_bus_data;
   logic         stbuf_bus_read_req, stbuf_bus_write_req;
   logic [31:0]  bus_stbuf_data;
   logic         bus_stbuf_read_ack, bus_stbuf_write_ack;
   logic [31:0]  bus_tcm_fetch_addr;
   logic         bus_tcm_fetch_rd;
   logic [127:0] tcm_bus_fetch_data;
   logic [31:0]  bus_tcm_stbuf_read_addr, bus_tcm_stbuf_write_addr;
   logic [1:0]   bus_tcm_stbuf_read_size, bus_tcm_stbuf_write_size;
   logic [31:0]  bus_tcm_stbuf_data;
   logic         bus_tcm_stbuf_rd, bus_tcm_stbuf_wr;
   logic [127:0] tcm_bus_stbuf_data;
   logic [31:0]  bus_clint_read_addr, bus_clint_write_addr;
   logic [1:0]   bus_clint_read_size, bus_clint_write_size;
   logic [31:0]  bus_clint_data;
   logic         bus_clint_rd, bus_clint_wr;
   logic [127:0] clint_bus_data;

   bus dut (
      .clk(clk), .rst(rst),
      .fetch_bus_addr(fetch_bus_addr), .fetch_bus_read_req(fetch_bus_read_req),
      .bus_fetch_data(bus_fetch_data), .bus_fetch_read_ack(bus_fetch_read_ack),
      .stbuf_bus_read_addr(stbuf_bus_read_addr), .stbuf_bus_write_addr(stbuf_bus_write_addr),
      .stbuf_bus_read_size(stbuf_bus_read_size), .stbuf_bus_write_size(stbuf_bus_write_size),
      .stbuf_bus_data(stbuf_bus_data),
      .stbuf_bus_read_req(stbuf_bus_read_req), .stbuf_bus_write_req(stbuf_bus_write_req),
      .bus_stbuf_data(bus_stbuf_data),
      .bus_stbuf_read_ack(bus_stbuf_read_ack), .bus_stbuf_write_ack(bus_stbuf_write_ack),
      .bus_tcm_fetch_addr(bus_tcm_fetch_addr), .bus_tcm_fetch_rd(bus_tcm_fetch_rd),
      .tcm_bus_fetch_data(tcm_bus_fetch_data),
      .bus_tcm_stbuf_read_addr(bus_tcm_stbuf_read_addr), .bus_tcm_stbuf_write_addr(bus_tcm_stbuf_write_addr),
      .bus_tcm_stbuf_read_size(bus_tcm_stbuf_read_size), .bus_tcm_stbuf_write_size(bus_tcm_stbuf_write_size),
      .bus_tcm_stbuf_data(bus_tcm_stbuf_data),
      .bus_tcm_stbuf_rd(bus_tcm_stbuf_rd), .bus_tcm_stbuf_wr(bus_tcm_stbuf_wr),
      .tcm_bus_stbuf_data(tcm_bus_stbuf_data),
      .bus_clint_read_addr(bus_clint_read_addr), .bus_clint_write_addr(bus_clint_write_addr),
      .bus_clint_read_size(bus_clint_read_size), .bus_clint_write_size(bus_clint_write_size),
      .bus_clint_data(bus_clint_data),
      .bus_clint_rd(bus_clint_rd), .bus_clint_wr(bus_clint_wr),
      .clint_bus_data(clint_bus_data)
   );

   int compared   = 0;
   int mismatched = 0;

   // Model state: what the previous clock edge left pending (0 none, 1 TCM, 2 CLINT)
   bit m_fetch_ack, m_rd_ack, m_wr_ack, m_fetch_tcm;
   int m_rd_src;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit hit(input logic [31:0] a, input logic [31:0] base, input logic [31:0] size);
      longint x, b, s;
      x = longint'(a);
      b = longint'(base);
      s = longint'(size);
      return (x >= b) && (x < b + s);
   endfunction

   task automatic apply(input bit r,
                        input logic [31:0] fa, input bit freq,
                        input logic [31:0] ra, input logic [1:0] rs, input bit rreq,
                        input logic [31:0] wa, input logic [1:0] ws, input logic [31:0] wd, input bit wreq,
                        input logic [127:0] tf, input logic [127:0] ts, input logic [127:0] cd);
      @(negedge clk);
      rst = r;
      fetch_bus_addr = fa;        fetch_bus_read_req = freq;
      stbuf_bus_read_addr = ra;   stbuf_bus_read_size = rs;   stbuf_bus_read_req = rreq;
      stbuf_bus_write_addr = wa;  stbuf_bus_write_size = ws;  stbuf_bus_data = wd;
      stbuf_bus_write_req = wreq;
      tcm_bus_fetch_data = tf;    tcm_bus_stbuf_data = ts;    clint_bus_data = cd;
      #1;
   endtask

   task automatic check_all();
      logic [31:0] e32;
      logic [127:0] e128;
      e32 = fetch_bus_addr - TCM_A;        chk("tcm_fetch_addr", bus_tcm_fetch_addr, e32);
      chk("tcm_fetch_rd", bus_tcm_fetch_rd, fetch_bus_read_req && hit(fetch_bus_addr, TCM_A, TCM_S));
      e32 = stbuf_bus_read_addr - TCM_A;   chk("tcm_rd_addr", bus_tcm_stbuf_read_addr, e32);
      e32 = stbuf_bus_write_addr - TCM_A;  chk("tcm_wr_addr", bus_tcm_stbuf_write_addr, e32);
      e32 = stbuf_bus_read_addr - CLINT_A; chk("clint_rd_addr", bus_clint_read_addr, e32);
      e32 = stbuf_bus_write_addr - CLINT_A; chk("clint_wr_addr", bus_clint_write_addr, e32);
      chk("tcm_rd_size", bus_tcm_stbuf_read_size, stbuf_bus_read_size);
      chk("tcm_wr_size", bus_tcm_stbuf_write_size, stbuf_bus_write_size);
      chk("clint_rd_size", bus_clint_read_size, stbuf_bus_read_size);
      chk("clint_wr_size", bus_clint_write_size, stbuf_bus_write_size);
      chk("tcm_wdata", bus_tcm_stbuf_data, stbuf_bus_data);
      chk("clint_wdata", bus_clint_data, stbuf_bus_data);
      chk("tcm_rd", bus_tcm_stbuf_rd, stbuf_bus_read_req && hit(stbuf_bus_read_addr, TCM_A, TCM_S));
      chk("tcm_wr", bus_tcm_stbuf_wr, stbuf_bus_write_req && hit(stbuf_bus_write_addr, TCM_A, TCM_S));
      chk("clint_rd", bus_clint_rd, stbuf_bus_read_req && hit(stbuf_bus_read_addr, CLINT_A, CLINT_S));
      chk("clint_wr", bus_clint_wr, stbuf_bus_write_req && hit(stbuf_bus_write_addr, CLINT_A, CLINT_S));
      chk("fetch_ack", bus_fetch_read_ack, m_fetch_ack);
      chk("rd_ack", bus_stbuf_read_ack, m_rd_ack);
      chk("wr_ack", bus_stbuf_write_ack, m_wr_ack);
      e128 = m_fetch_tcm ? tcm_bus_fetch_data : 128'h0;
      chk("fetch_data", bus_fetch_data, e128);
      e32 = (m_rd_src == 1) ? tcm_bus_stbuf_data[31:0] : (m_rd_src == 2) ? clint_bus_data[31:0] : 32'h0;
      chk("stbuf_data", bus_stbuf_data, e32);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_fetch_ack = 0; m_rd_ack = 0; m_wr_ack = 0; m_fetch_tcm = 0; m_rd_src = 0;
      end else begin
         m_fetch_ack = fetch_bus_read_req;
         m_rd_ack    = stbuf_bus_read_req;
         m_wr_ack    = stbuf_bus_write_req;
         m_fetch_tcm = fetch_bus_read_req && hit(fetch_bus_addr, TCM_A, TCM_S);
         m_rd_src    = !stbuf_bus_read_req ? 0 :
                       hit(stbuf_bus_read_addr, TCM_A, TCM_S) ? 1 :
                       hit(stbuf_bus_read_addr, CLINT_A, CLINT_S) ? 2 : 0;
      end
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 8))
         0: return TCM_A + ($urandom & 32'h0000_fffc);
         1: return CLINT_A + ($urandom & 32'h0000_fffc);
         2: return $urandom;
         3: return TCM_A - 32'd1;
         4: return TCM_A + TCM_S - 32'd1;
         5: return TCM_A + TCM_S;
         6: return CLINT_A - 32'd1;
         7: return CLINT_A + CLINT_S;
         default: return TCM_A;
      endcase
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   localparam logic [127:0] TF = 128'habbccdde_12574985_1000203f_abcdef12;
   localparam logic [127:0] TS = 128'hacaedffe_01234567_89abcdef_fedd1698;
   localparam logic [127:0] CD = 128'h11111111_22222222_33333333_bbccaadd;

   initial begin
      m_fetch_ack = 0; m_rd_ack = 0; m_wr_ack = 0; m_fetch_tcm = 0; m_rd_src = 0;
      // Reset with everything idle
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_all();
      chk("s1_rd_ack", bus_stbuf_read_ack, 1'b0);
      tick();

      // TCM fetch, read and write together
      apply(0, TCM_A + 32'h10, 1, TCM_A + 32'h20, 2'b01, 1, TCM_A + 32'h30, 2'b10, 32'hdeadbeef, 1, 0, 0, 0);
      check_all();
      chk("s2_fetch_off", bus_tcm_fetch_addr, 32'h10);
      chk("s2_rd_off", bus_tcm_stbuf_read_addr, 32'h20);
      chk("s2_wr_off", bus_tcm_stbuf_write_addr, 32'h30);
      chk("s2_clint_rd", bus_clint_rd, 1'b0);
      tick();

      // Step 2 responses; retarget read/write to CLINT
      apply(0, 0, 0, CLINT_A + 32'h40, 2'b10, 1, CLINT_A + 32'h50, 2'b10, 32'h0badf00d, 1, TF, TS, 0);
      check_all();
      chk("s2_fetch_data", bus_fetch_data, TF);
      chk("s2_stbuf_data", bus_stbuf_data, 32'hfedd1698);
      chk("s3_clint_rd_off", bus_clint_read_addr, 32'h40);
      chk("s3_clint_wr_off", bus_clint_write_addr, 32'h50);
      chk("s3_tcm_rd", bus_tcm_stbuf_rd, 1'b0);
      tick();

      // CLINT responses; read unmapped address 0
      apply(0, 0, 0, 32'h0, 2'b10, 1, 0, 0, 0, 0, 0, TS, CD);
      check_all();
      chk("s3_stbuf_data", bus_stbuf_data, 32'hbbccaadd);
      chk("s4_clint_rd", bus_clint_rd, 1'b0);
      tick();

      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, TF, TS, CD);
      check_all();
      chk("s4_rd_ack", bus_stbuf_read_ack, 1'b1);
      chk("s4_rd_data", bus_stbuf_data, 32'h0);
      tick();

      // Reset with all requests pending discards their acks
      apply(1, TCM_A, 1, TCM_A, 2'b10, 1, TCM_A, 2'b10, 32'h1, 1, TF, TS, CD);
      check_all();
      tick();
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, TF, TS, CD);
      check_all();
      chk("s5_fetch_ack", bus_fetch_read_ack, 1'b0);
      chk("s5_wr_ack", bus_stbuf_write_ack, 1'b0);
      tick();

      // Single-cycle request yields exactly one ack
      apply(0, TCM_A + 32'h100, 1, CLINT_A + 32'h4, 2'b00, 1, TCM_A + 32'h8, 2'b00, 32'h5a, 1, TF, TS, CD);
      check_all();
      tick();
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, TF, TS, CD);
      check_all();
      chk("s6_ack_once", bus_stbuf_write_ack, 1'b1);
      tick();
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, TF, TS, CD);
      check_all();
      chk("s6_ack_gone", bus_stbuf_write_ack, 1'b0);
      tick();

      // Randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         apply(($urandom_range(0, 31) == 0),
               pick_addr(), 1'($urandom),
               pick_addr(), 2'($urandom_range(0, 2)), 1'($urandom),
               pick_addr(), 2'($urandom_range(0, 2)), $urandom, 1'($urandom),
               rnd128(), rnd128(), rnd128());
         check_all();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
